// File: rtl/sbqm_pkg.sv
// Shared constants and types for the SBqm queue counter and waiting-time ROM.
package sbqm_pkg;

  localparam int unsigned N_DEF = 3;
  localparam int unsigned MAX_P = (1 << N_DEF) - 1;

  typedef logic [1:0] teller_t;

endpackage : sbqm_pkg

// File: rtl/sensor_edge.sv
// Photocell front end: two-flop synchroniser, optional debounce, rising-edge pulse.
// Optional macro: QCNT_DEBOUNCE_EN enables the DB_CYCLES debounce filter.
module sensor_edge
`ifdef QCNT_DEBOUNCE_EN
  #(
    parameter int unsigned DB_CYCLES = 4
  )
`endif
  (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse_c
  );

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic       lvl;
  logic [1:0] warm;
  logic       primed;

  // Valid samples exist only once the synchroniser has refilled after reset;
  // the first of them seeds the edge detector instead of producing a pulse.
  assign primed = (warm == 2'd3);

  // Two-flop synchroniser for the asynchronous sensor level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= level;
      sync2 <= sync1;
    end
  end

  // Post-reset warm-up counter, saturates once the detector is primed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warm <= 2'd0;
    end else if (!primed) begin
      warm <= warm + 2'd1;
    end
  end

`ifdef QCNT_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          acc;
  logic [CW-1:0] cnt;

  // Accept a new level only after DB_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 1'b0;
      cnt <= '0;
    end else if (!primed) begin
      acc <= sync2;
      cnt <= '0;
    end else if (sync2 == acc) begin
      cnt <= '0;
    end else if (cnt == CW'(DB_CYCLES - 1)) begin
      acc <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign lvl = acc;
`else
  assign lvl = sync2;
`endif

  // Previous-level register; while priming it tracks the raw synchronised level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev <= 1'b0;
    end else begin
      prev <= primed ? lvl : sync2;
    end
  end

  // One pulse per rising edge of the accepted level.
  always_comb begin
    pulse_c = lvl & ~prev & primed;
  end

endmodule : sensor_edge

// File: rtl/queue_counter.sv
// Customer queue counter feeding the SBqm waiting-time ROM address.
// Optional macro: QCNT_DEBOUNCE_EN adds a DB_CYCLES debounce on both sensors.
module queue_counter
  import sbqm_pkg::*;
  #(
    parameter int unsigned N         = N_DEF,
    parameter int unsigned DB_CYCLES = 4
  )
  (
    input  logic         clk,
    input  logic         rst,
    input  logic         sens_in,
    input  logic         sens_out,
    input  teller_t      tcount_sw,
    output logic [N-1:0] pcount,
    output teller_t      tcount,
    output logic         full,
    output logic         empty,
    output logic         ovf_err,
    output logic         udf_err
  );

  localparam logic [N-1:0] PMAX = '1;

  // Reject degenerate configurations at elaboration.
  if (N < 1 || DB_CYCLES < 1) begin : g_param_check
    $error("queue_counter: N and DB_CYCLES must be at least 1");
  end

  logic         in_pulse;
  logic         out_pulse;
  teller_t      tsync1;
  logic [N-1:0] pcount_next;
  logic         ovf_next;
  logic         udf_next;

`ifdef QCNT_DEBOUNCE_EN
  sensor_edge #(.DB_CYCLES(DB_CYCLES)) u_edge_in (
    .clk(clk), .rst(rst), .level(sens_in), .pulse_c(in_pulse)
  );
  sensor_edge #(.DB_CYCLES(DB_CYCLES)) u_edge_out (
    .clk(clk), .rst(rst), .level(sens_out), .pulse_c(out_pulse)
  );
`else
  sensor_edge u_edge_in (
    .clk(clk), .rst(rst), .level(sens_in), .pulse_c(in_pulse)
  );
  sensor_edge u_edge_out (
    .clk(clk), .rst(rst), .level(sens_out), .pulse_c(out_pulse)
  );
`endif

  // Teller-select switch synchroniser; the second stage is the output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tsync1 <= 2'd0;
      tcount <= 2'd0;
    end else begin
      tsync1 <= tcount_sw;
      tcount <= tsync1;
    end
  end

  // Saturating count update and error detection from the edge pulses.
  always_comb begin
    pcount_next = pcount;
    ovf_next    = 1'b0;
    udf_next    = 1'b0;
    if (in_pulse && !out_pulse) begin
      if (full) ovf_next    = 1'b1;
      else      pcount_next = pcount + N'(1);
    end else if (out_pulse && !in_pulse) begin
      if (empty) udf_next    = 1'b1;
      else       pcount_next = pcount - N'(1);
    end
  end

  // Count, status flags and error pulses, all registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcount  <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      pcount  <= pcount_next;
      full    <= (pcount_next == PMAX);
      empty   <= (pcount_next == '0);
      ovf_err <= ovf_next;
      udf_err <= udf_next;
    end
  end

endmodule : queue_counter

// File: tb/tb_queue_counter.sv
// Directed self-checking bench for queue_counter (N=3, DB_CYCLES=4).
module tb_queue_counter;

  localparam int unsigned N  = 3;
  localparam int unsigned DB = 4;
`ifdef QCNT_DEBOUNCE_EN
  localparam int unsigned LAT = 3 + DB;
`else
  localparam int unsigned LAT = 3;
`endif
  localparam int unsigned SETTLE = 14;

  logic         clk = 1'b0;
  logic         rst;
  logic         sens_in;
  logic         sens_out;
  logic [1:0]   tcount_sw;
  logic [N-1:0] pcount;
  logic [1:0]   tcount;
  logic         full;
  logic         empty;
  logic         ovf_err;
  logic         udf_err;

  int tests = 0;
  int fails = 0;

  queue_counter #(.N(N), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sens_in(sens_in), .sens_out(sens_out),
    .tcount_sw(tcount_sw), .pcount(pcount), .tcount(tcount),
    .full(full), .empty(empty), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a pulse of len cycles on the chosen sensors, then let it settle.
  task automatic pulse(input logic in_v, input logic out_v, input int len);
    sens_in  = in_v;
    sens_out = out_v;
    tick(len);
    sens_in  = 1'b0;
    sens_out = 1'b0;
    tick(SETTLE);
  endtask

  task automatic test_reset;
    rst = 1'b1; sens_in = 1'b0; sens_out = 1'b0; tcount_sw = 2'd0;
    tick(2);
    tests++;
    if (pcount !== 3'd0 || tcount !== 2'd0 || full !== 1'b0 || empty !== 1'b1 ||
        ovf_err !== 1'b0 || udf_err !== 1'b0) begin
      fails++;
      $display("FAIL reset: pcount=%0d tcount=%0d full=%b empty=%b ovf=%b udf=%b, want 0 0 0 1 0 0",
               pcount, tcount, full, empty, ovf_err, udf_err);
    end
    rst = 1'b0;
    tick(6);
  endtask

  task automatic test_single_entry;
    sens_in = 1'b1;
    tick(LAT - 1);
    tests++;
    if (pcount !== 3'd0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL single_early: pcount=%0d empty=%b, want 0 1", pcount, empty);
    end
    tick(1);
    tests++;
    if (pcount !== 3'd1 || empty !== 1'b0 || ovf_err !== 1'b0 || udf_err !== 1'b0) begin
      fails++;
      $display("FAIL single_count: pcount=%0d empty=%b ovf=%b udf=%b, want 1 0 0 0",
               pcount, empty, ovf_err, udf_err);
    end
    tick(2);
    sens_in = 1'b0;
    tick(SETTLE);
    tests++;
    if (pcount !== 3'd1) begin
      fails++;
      $display("FAIL single_hold: pcount=%0d, want 1", pcount);
    end
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0, 6);
    tests++;
    if (pcount !== 3'd7 || full !== 1'b1 || empty !== 1'b0) begin
      fails++;
      $display("FAIL fill: pcount=%0d full=%b empty=%b, want 7 1 0", pcount, full, empty);
    end
    sens_in = 1'b1;
    tick(LAT - 1);
    tests++;
    if (ovf_err !== 1'b0) begin
      fails++;
      $display("FAIL ovf_early: ovf=%b, want 0", ovf_err);
    end
    tick(1);
    tests++;
    if (ovf_err !== 1'b1 || pcount !== 3'd7 || full !== 1'b1) begin
      fails++;
      $display("FAIL ovf_pulse: ovf=%b pcount=%0d full=%b, want 1 7 1", ovf_err, pcount, full);
    end
    tick(1);
    tests++;
    if (ovf_err !== 1'b0 || pcount !== 3'd7) begin
      fails++;
      $display("FAIL ovf_one_cycle: ovf=%b pcount=%0d, want 0 7", ovf_err, pcount);
    end
    tick(4);
    sens_in = 1'b0;
    tick(SETTLE);
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 6);
    tests++;
    if (pcount !== 3'd2 || full !== 1'b0) begin
      fails++;
      $display("FAIL decrement: pcount=%0d full=%b, want 2 0", pcount, full);
    end
    sens_in = 1'b1; sens_out = 1'b1;
    tick(LAT);
    tests++;
    if (pcount !== 3'd2 || ovf_err !== 1'b0 || udf_err !== 1'b0) begin
      fails++;
      $display("FAIL simul: pcount=%0d ovf=%b udf=%b, want 2 0 0", pcount, ovf_err, udf_err);
    end
    tick(1);
    tests++;
    if (pcount !== 3'd2) begin
      fails++;
      $display("FAIL simul_hold: pcount=%0d, want 2", pcount);
    end
    tick(4);
    sens_in = 1'b0; sens_out = 1'b0;
    tick(SETTLE);
  endtask

  task automatic test_underflow;
    pulse(1'b0, 1'b1, 6);
    pulse(1'b0, 1'b1, 6);
    tests++;
    if (pcount !== 3'd0 || empty !== 1'b1) begin
      fails++;
      $display("FAIL drain: pcount=%0d empty=%b, want 0 1", pcount, empty);
    end
    sens_out = 1'b1;
    tick(LAT);
    tests++;
    if (udf_err !== 1'b1 || pcount !== 3'd0 || empty !== 1'b1 || ovf_err !== 1'b0) begin
      fails++;
      $display("FAIL udf_pulse: udf=%b pcount=%0d empty=%b ovf=%b, want 1 0 1 0",
               udf_err, pcount, empty, ovf_err);
    end
    tick(1);
    tests++;
    if (udf_err !== 1'b0 || pcount !== 3'd0) begin
      fails++;
      $display("FAIL udf_one_cycle: udf=%b pcount=%0d, want 0 0", udf_err, pcount);
    end
    tick(4);
    sens_out = 1'b0;
    tick(SETTLE);
  endtask

  task automatic test_tcount;
    tcount_sw = 2'd3;
    tick(1);
    tests++;
    if (tcount !== 2'd0) begin
      fails++;
      $display("FAIL tcount_early: tcount=%0d, want 0", tcount);
    end
    tick(1);
    tests++;
    if (tcount !== 2'd3) begin
      fails++;
      $display("FAIL tcount_3: tcount=%0d, want 3", tcount);
    end
    tcount_sw = 2'd1;
    tick(2);
    tests++;
    if (tcount !== 2'd1 || pcount !== 3'd0) begin
      fails++;
      $display("FAIL tcount_1: tcount=%0d pcount=%0d, want 1 0", tcount, pcount);
    end
    tcount_sw = 2'd0;
    tick(2);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 6);
    tests++;
    if (pcount !== 3'd5) begin
      fails++;
      $display("FAIL refill: pcount=%0d, want 5", pcount);
    end
    sens_in = 1'b1;
    tick(1);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (pcount !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: pcount=%0d empty=%b full=%b, want 0 1 0", pcount, empty, full);
    end
    tick(2);
    rst = 1'b0;
    tick(SETTLE);
    tests++;
    if (pcount !== 3'd0 || ovf_err !== 1'b0) begin
      fails++;
      $display("FAIL held_across_reset: pcount=%0d ovf=%b, want 0 0", pcount, ovf_err);
    end
    sens_in = 1'b0;
    tick(SETTLE);
    sens_in = 1'b1;
    tick(LAT - 1);
    tests++;
    if (pcount !== 3'd0) begin
      fails++;
      $display("FAIL re_edge_early: pcount=%0d, want 0", pcount);
    end
    tick(1);
    tests++;
    if (pcount !== 3'd1) begin
      fails++;
      $display("FAIL re_edge_count: pcount=%0d, want 1", pcount);
    end
    tick(4);
    sens_in = 1'b0;
    tick(SETTLE);
  endtask

`ifdef QCNT_DEBOUNCE_EN
  task automatic test_debounce;
    pulse(1'b1, 1'b0, 2);
    tests++;
    if (pcount !== 3'd1) begin
      fails++;
      $display("FAIL glitch: pcount=%0d, want 1", pcount);
    end
    sens_in = 1'b1;
    tick(LAT - 1);
    tests++;
    if (pcount !== 3'd1) begin
      fails++;
      $display("FAIL db_early: pcount=%0d, want 1", pcount);
    end
    tick(1);
    tests++;
    if (pcount !== 3'd2) begin
      fails++;
      $display("FAIL db_count: pcount=%0d, want 2", pcount);
    end
    sens_in = 1'b0;
    tick(SETTLE);
  endtask
`endif

  initial begin
    test_reset;
    test_single_entry;
    test_fill_overflow;
    test_simultaneous;
    test_underflow;
    test_tcount;
    test_reset_mid;
`ifdef QCNT_DEBOUNCE_EN
    test_debounce;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_queue_counter
